// File: rtl/uart_tx_buffered.sv
// Byte-wide FIFO feeding an 8N1 UART serializer.
// Frames are sent back-to-back whenever bytes are queued; uart_tx idles high.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DEPTH        = 16
) (
  input  logic                     sysclk,
  input  logic                     cpu_resetn,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow,
  output logic                     uart_tx,
  output logic [1:0]               dbg_state
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [15:0]     L_BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]  L_FULL     = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_baud;
  logic [15:0]      w_baud_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_tx;
  logic             w_tx_nxt;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_baud_done;

  // A write is judged against the registered full flag, so a pop on the same
  // edge does not rescue a write presented while the FIFO is full.
  assign w_full      = (r_count == L_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = wr_en && !w_full;
  assign w_baud_done = (r_baud == L_BAUD_MAX);

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud + 16'd1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = S_DATA;
          w_tx_nxt      = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          // Next queued byte starts on the very edge the stop bit ends.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign busy      = (r_state != S_IDLE);
  assign overflow  = r_overflow;
  assign uart_tx   = r_tx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLKS_PER_BIT=4, DEPTH=4: per-cycle frame
// vectors, a line monitor feeding a byte scoreboard, and reset/overflow corner cases.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  logic       sysclk;
  logic       cpu_resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       busy;
  logic       overflow;
  logic       uart_tx;
  logic [1:0] dbg_state;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .sysclk    (sysclk),
    .cpu_resetn(cpu_resetn),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .busy      (busy),
    .overflow  (overflow),
    .uart_tx   (uart_tx),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  logic       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; the write lands on the next rising edge.
  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge sysclk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy || !empty || exp_q.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    chk("drain_exp_q_left", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
    chk("drain_empty", empty, 1);
    step(3);
  endtask

  // ---------------- line monitor ----------------
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;
  initial begin
    forever begin
      @(negedge sysclk);
      if (mon_en && cpu_resetn && uart_tx == 1'b0) begin
        start_cyc.push_back(cyc);
        repeat (2) @(negedge sysclk);
        chk("rx_start_mid", uart_tx, 0);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge sysclk);
          rx_byte[k] = uart_tx;
        end
        repeat (4) @(negedge sysclk);
        chk("rx_stop_mid", uart_tx, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got byte %0h expected none (cyc %0d)", rx_byte, cyc);
        end else begin
          rx_exp = exp_q.pop_front();
          chk("rx_byte", rx_byte, rx_exp);
        end
      end
    end
  end

  // ---------------- frame vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = uart_tx level during bit slot i (start..stop)
  } frame_vec_t;

  frame_vec_t vecs[5];
  int         c0;

  initial begin
    vecs[0] = '{data: 8'h55, line: 10'h2AA};
    vecs[1] = '{data: 8'h00, line: 10'h200};
    vecs[2] = '{data: 8'hFF, line: 10'h3FE};
    vecs[3] = '{data: 8'hA5, line: 10'h34A};
    vecs[4] = '{data: 8'h3C, line: 10'h278};

    wr_en      = 1'b0;
    wr_data    = 8'h00;
    cpu_resetn = 1'b0;
    #23;
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    #4 cpu_resetn = 1'b1;
    step(1);

    // Per-cycle frame shape for single bytes into an idle block.
    for (int v = 0; v < 5; v++) begin
      push_byte(vecs[v].data);
      chk("vec_count_after_write", count, 1);
      chk("vec_line_idle_e0", uart_tx, 1);
      chk("vec_busy_e0", busy, 0);
      @(posedge sysclk);
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < CPB; c++) begin
          @(negedge sysclk);
          chk("vec_line_bit", uart_tx, vecs[v].line[b]);
        end
      end
      chk("vec_busy_last_stop_cycle", busy, 1);
      @(negedge sysclk);
      chk("vec_busy_after_frame", busy, 0);
      chk("vec_empty_after_frame", empty, 1);
      chk("vec_count_after_frame", count, 0);
      chk("vec_line_after_frame", uart_tx, 1);
      step(1);
    end

    mon_en = 1'b1;

    // Back-to-back writes: stop of frame 1 runs straight into start of frame 2.
    start_cyc.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    push_byte(8'hA5);
    push_byte(8'h3C);
    drain(200);
    chk("b2b_frame_count", start_cyc.size(), 2);
    if (start_cyc.size() == 2)
      chk("b2b_start_spacing", start_cyc[1] - start_cyc[0], 10 * CPB);

    // Streaming through a 4-entry FIFO wraps both pointers.
    for (int i = 0; i < 10; i++) begin
      int n;
      n = 0;
      while (full && n < 100) begin
        step(1);
        n++;
      end
      exp_q.push_back(8'(i));
      push_byte(8'(i));
    end
    chk("wrap_overflow", overflow, 0);
    drain(600);
    chk("wrap_overflow_end", overflow, 0);

    // Overflow: serializer busy, five writes into four slots.
    exp_q.push_back(8'h11);
    push_byte(8'h11);
    step(1);
    chk("ovf_busy", busy, 1);
    chk("ovf_pre_flag", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h21 + 8'(i));
      push_byte(8'h21 + 8'(i));
    end
    chk("ovf_count_4", count, 4);
    chk("ovf_full", full, 1);
    chk("ovf_flag_not_yet", overflow, 0);
    push_byte(8'h25);
    chk("ovf_count_still_4", count, 4);
    chk("ovf_flag_set", overflow, 1);
    drain(400);
    chk("ovf_flag_sticky", overflow, 1);

    // Reset mid-cycle with a write already presented; it must land on the first edge.
    #2 cpu_resetn = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h61;
    #1;
    chk("rst2_overflow_cleared", overflow, 0);
    chk("rst2_count", count, 0);
    #2 cpu_resetn = 1'b1;
    @(posedge sysclk);
    #1;
    wr_en = 1'b0;
    chk("first_write_after_reset", count, 1);
    c0 = cyc;
    exp_q.push_back(8'h61);

    // Full FIFO and a STOP->START pop on the same edge as a write.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h71 + 8'(i));
      push_byte(8'h71 + 8'(i));
    end
    chk("sim_count_4", count, 4);
    chk("sim_full", full, 1);
    while (cyc < c0 + 10 * CPB) step(1);
    chk("sim_pre_overflow", overflow, 0);
    chk("sim_pre_busy", busy, 1);
    push_byte(8'h99);
    chk("sim_overflow", overflow, 1);
    chk("sim_count_3", count, 3);
    chk("sim_full_clear", full, 0);
    chk("sim_restart_state", dbg_state, ST_START);
    chk("sim_restart_line", uart_tx, 0);
    drain(400);

    // Reset during DATA bit 3 with two bytes queued.
    mon_en = 1'b0;
    step(1);
    push_byte(8'h00);
    c0 = cyc;
    push_byte(8'h81);
    push_byte(8'h82);
    while (cyc < c0 + 18) step(1);
    chk("mid_pre_state", dbg_state, ST_DATA);
    chk("mid_pre_line", uart_tx, 0);
    chk("mid_pre_count", count, 2);
    #2 cpu_resetn = 1'b0;
    #1;
    chk("mid_rst_line", uart_tx, 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    #2 cpu_resetn = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
        step(1);
        if (uart_tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
      end
      chk("post_reset_idle_bad_cycles", bad, 0);
    end
    mon_en = 1'b1;
    exp_q.push_back(8'h5A);
    push_byte(8'h5A);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
